// File: rtl/rvb_pkg.sv
// Shared constants for the bitmanip carry-less divider: funct encoding and configuration helpers.
// Combinational only; no latency or backpressure of its own.
package rvb_pkg;

  localparam logic FUNCT_CLDIV = 1'b0;
  localparam logic FUNCT_CLREM = 1'b1;

  localparam int XLEN_DEF = 64;
  localparam int BPC_DEF  = 8;

  function automatic bit cfg_ok(input int xlen, input int bpc);
    return ((xlen == 32) || (xlen == 64)) && (bpc > 0) && ((32 % bpc) == 0);
  endfunction

  function automatic int iter_cycles(input int width, input int bpc);
    return width / bpc;
  endfunction

endpackage

// File: rtl/rvb_cldiv_if.sv
// din/dout valid-ready bundle between the bitmanip execute stage and the carry-less divider.
// Pure wiring; the divider owns din_ready/dout_valid/dout_rd, the stage owns the rest.
interface rvb_cldiv_if #(
  parameter int XLEN = 64
) ();

  logic            din_valid;
  logic            din_ready;
  logic [XLEN-1:0] din_rs1;
  logic [XLEN-1:0] din_rs2;
  logic            din_insn3;
  logic            din_insn13;
  logic            dout_valid;
  logic            dout_ready;
  logic [XLEN-1:0] dout_rd;

  modport master (
    output din_valid, din_rs1, din_rs2, din_insn3, din_insn13, dout_ready,
    input  din_ready, dout_valid, dout_rd
  );

  modport slave (
    input  din_valid, din_rs1, din_rs2, din_insn3, din_insn13, dout_ready,
    output din_ready, dout_valid, dout_rd
  );

endinterface

// File: rtl/rvb_cldiv_lzd.sv
// Leading-one detector for the divisor; word mode looks only at the low 32 bits.
// Combinational, zero latency, no backpressure.
module rvb_cldiv_lzd #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]         i_val,
  input  logic                    i_word,
  output logic [$clog2(XLEN)-1:0] o_idx,
  output logic                    o_zero
);

  localparam int DW = $clog2(XLEN);

  logic [XLEN-1:0] w_val;

  always_comb begin
    w_val = i_val;
    if (i_word) begin
      for (int i = 32; i < XLEN; i++) w_val[i] = 1'b0;
    end
    o_idx = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (w_val[i]) o_idx = DW'(i);
    end
    o_zero = (w_val == '0);
  end

endmodule

// File: rtl/rvb_cldiv.sv
// Iterative GF(2) divider (CLDIV/CLREM), BPC quotient bits per cycle; result L/BPC edges after accept.
// Result held while dout_ready is low; a new accept may share the output handshake edge.
module rvb_cldiv
  import rvb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int BPC  = BPC_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  rvb_cldiv_if.slave  bus
);

  localparam int CW = $clog2(XLEN + 1);
  localparam int DW = $clog2(XLEN);
  localparam int SH = XLEN - 32;
  localparam int NCYC_FULL = iter_cycles(XLEN, BPC);
  localparam int NCYC_WORD = iter_cycles(32, BPC);

  if (!cfg_ok(XLEN, BPC)) begin : g_bad_cfg
    $error("rvb_cldiv: XLEN must be 32 or 64 and BPC must divide 32");
  end

  logic            r_busy;
  logic [CW-1:0]   r_state;
  logic [CW-1:0]   r_j;
  logic [CW-1:0]   r_s;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] r_r;
  logic [XLEN-1:0] r_bn;
  logic            r_funct;
  logic            r_w;

  logic            w_acc;
  logic            w_word;
  logic            w_dout_vld;
  logic [XLEN-1:0] w_rs1a;
  logic [XLEN-1:0] w_rs2a;
  logic [DW-1:0]   w_idx;
  logic            w_zero;
  logic [CW-1:0]   w_d;
  logic [CW-1:0]   w_sh;
  logic [XLEN-1:0] w_q_nxt;
  logic [XLEN-1:0] w_r_nxt;
  logic [DW-1:0]   w_pos;
  logic            w_bit;
  logic [XLEN-1:0] w_q_out;
  logic [XLEN-1:0] w_r_out;

  // Word operands are left-aligned so the step logic always works from bit XLEN-1 down.
  assign w_word = bus.din_insn3 && (XLEN == 64);
  assign w_rs1a = w_word ? (bus.din_rs1 << SH) : bus.din_rs1;
  assign w_rs2a = w_word ? (bus.din_rs2 << SH) : bus.din_rs2;

  rvb_cldiv_lzd #(.XLEN(XLEN)) u_lzd (
    .i_val  (bus.din_rs2),
    .i_word (w_word),
    .o_idx  (w_idx),
    .o_zero (w_zero)
  );

  assign w_d  = w_word ? (CW'(w_idx) + CW'(SH)) : CW'(w_idx);
  assign w_sh = CW'(XLEN - 1) - w_d;

  assign w_dout_vld     = (r_state == '0) && r_busy && resetn;
  assign bus.dout_valid = w_dout_vld;
  assign bus.din_ready  = (r_state == '0) && (!r_busy || (w_dout_vld && bus.dout_ready)) && resetn;
  assign w_acc          = bus.din_valid && bus.din_ready;

  always_comb begin
    w_q_nxt = r_q;
    w_r_nxt = r_r;
    w_pos   = '0;
    w_bit   = 1'b0;
    for (int k = 0; k < BPC; k++) begin
      if ((int'(r_j) + k) < int'(r_s)) begin
        w_pos   = DW'(XLEN - 1 - (int'(r_j) + k));
        w_bit   = w_r_nxt[w_pos];
        w_q_nxt = {w_q_nxt[XLEN-2:0], w_bit};
        if (w_bit) w_r_nxt = w_r_nxt ^ (r_bn >> (int'(r_j) + k));
      end
    end
  end

  // Quotient sits in the low bits, remainder in the high bits when in word mode.
  assign w_q_out     = r_w ? XLEN'($signed(r_q << SH) >>> SH) : r_q;
  assign w_r_out     = r_w ? XLEN'($signed(r_r) >>> SH) : r_r;
  assign bus.dout_rd = (r_funct == FUNCT_CLDIV) ? w_q_out : w_r_out;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_busy  <= 1'b0;
      r_state <= '0;
      r_j     <= '0;
      r_s     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_bn    <= '0;
      r_funct <= 1'b0;
      r_w     <= 1'b0;
    end else if (w_acc) begin
      r_busy  <= 1'b1;
      r_state <= w_word ? CW'(NCYC_WORD) : CW'(NCYC_FULL);
      r_j     <= '0;
      r_s     <= w_zero ? '0 : (CW'(XLEN) - w_d);
      r_q     <= w_zero ? '1 : '0;
      r_r     <= w_rs1a;
      r_bn    <= w_rs2a << w_sh;
      r_funct <= bus.din_insn13;
      r_w     <= w_word;
    end else if (r_state != '0) begin
      r_state <= r_state - 1'b1;
      r_j     <= r_j + CW'(BPC);
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
    end else if (w_dout_vld && bus.dout_ready) begin
      r_busy  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rvb_cldiv.sv
// Directed and random checks of rvb_cldiv (XLEN=64, BPC=8) against a long-division reference.
module tb_rvb_cldiv;
  import rvb_pkg::*;

  localparam int XLEN = 64;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  rvb_cldiv_if #(.XLEN(XLEN)) u_if ();

  rvb_cldiv #(.XLEN(XLEN), .BPC(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (u_if)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sext_w(input logic [63:0] v, input bit w);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  // Textbook polynomial long division over GF(2).
  function automatic void ref_divrem(input logic [63:0] a_in, input logic [63:0] b_in,
                                     input bit w, output logic [63:0] q, output logic [63:0] r);
    int          len = w ? 32 : 64;
    int          db  = -1;
    logic [63:0] a   = a_in;
    logic [63:0] b   = b_in;
    if (w) begin
      a[63:32] = '0;
      b[63:32] = '0;
    end
    for (int i = 0; i < len; i++) if (b[i]) db = i;
    q = '0;
    r = a;
    if (db < 0) begin
      q = w ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      for (int i = len - 1; i >= db; i--) begin
        if (r[i]) begin
          q[i-db] = 1'b1;
          r       = r ^ (b << (i - db));
        end
      end
    end
    q = sext_w(q, w);
    r = sext_w(r, w);
  endfunction

  function automatic logic [63:0] clmul(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] p = '0;
    for (int i = 0; i < 64; i++) if (b[i]) p = p ^ (a << i);
    return p;
  endfunction

  task automatic accept_op(input logic [63:0] rs1, input logic [63:0] rs2, input bit w, input bit rem);
    int n = 0;
    u_if.din_rs1    = rs1;
    u_if.din_rs2    = rs2;
    u_if.din_insn3  = w;
    u_if.din_insn13 = rem;
    u_if.din_valid  = 1'b1;
    while (!u_if.din_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("accept_ready", {63'b0, u_if.din_ready}, 64'd1);
    @(posedge clock); #1;
    u_if.din_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!u_if.dout_valid && lat < 64) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic take_result(output logic [63:0] res);
    res = u_if.dout_rd;
    u_if.dout_ready = 1'b1;
    @(posedge clock); #1;
    u_if.dout_ready = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] rs1, input logic [63:0] rs2, input bit w, input bit rem,
                        output logic [63:0] res, output int lat);
    accept_op(rs1, rs2, w, rem);
    wait_result(lat);
    take_result(res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res, res_q, res_r, a, b, eq, er;
    int          lat;
    bit          w, seen;

    u_if.din_valid  = 1'b0;
    u_if.din_rs1    = '0;
    u_if.din_rs2    = '0;
    u_if.din_insn3  = 1'b0;
    u_if.din_insn13 = 1'b0;
    u_if.dout_ready = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_din_ready", {63'b0, u_if.din_ready}, 64'd0);
    chk("rst_dout_valid", {63'b0, u_if.dout_valid}, 64'd0);
    resetn = 1'b1;
    #1;
    chk("post_rst_din_ready", {63'b0, u_if.din_ready}, 64'd1);

    run_op(64'h15, 64'h3, 1'b0, FUNCT_CLDIV, res, lat);
    chk("q_15_3", res, 64'hC);
    chk("lat_64", 64'(lat), 64'd8);
    run_op(64'h15, 64'h3, 1'b0, FUNCT_CLREM, res, lat);
    chk("r_15_3", res, 64'h1);

    run_op(64'h31, 64'h7, 1'b0, FUNCT_CLDIV, res, lat);
    chk("q_31_7", res, 64'hB);
    run_op(64'h31, 64'h7, 1'b0, FUNCT_CLREM, res, lat);
    chk("r_31_7", res, 64'h0);

    run_op(64'hFFFF_FFFF_8000_0000, 64'h1, 1'b1, FUNCT_CLDIV, res, lat);
    chk("q_word", res, 64'hFFFF_FFFF_8000_0000);
    chk("lat_word", 64'(lat), 64'd4);
    run_op(64'hFFFF_FFFF_8000_0000, 64'h1, 1'b1, FUNCT_CLREM, res, lat);
    chk("r_word", res, 64'h0);

    run_op(64'h1234, 64'h0, 1'b0, FUNCT_CLDIV, res, lat);
    chk("q_div0", res, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("lat_div0", 64'(lat), 64'd8);
    run_op(64'h1234, 64'h0, 1'b0, FUNCT_CLREM, res, lat);
    chk("r_div0", res, 64'h1234);
    run_op(64'h1234, 64'h0, 1'b1, FUNCT_CLDIV, res, lat);
    chk("q_div0_word", res, 64'hFFFF_FFFF_FFFF_FFFF);

    // Backpressure hold, then output handshake and new accept on the same edge.
    accept_op(64'h31, 64'h7, 1'b0, FUNCT_CLDIV);
    wait_result(lat);
    chk("hold_lat", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("hold_valid", {63'b0, u_if.dout_valid}, 64'd1);
      chk("hold_rd", u_if.dout_rd, 64'hB);
      chk("hold_din_ready", {63'b0, u_if.din_ready}, 64'd0);
    end
    u_if.din_rs1    = 64'h15;
    u_if.din_rs2    = 64'h3;
    u_if.din_insn3  = 1'b0;
    u_if.din_insn13 = FUNCT_CLREM;
    u_if.din_valid  = 1'b1;
    u_if.dout_ready = 1'b1;
    #1;
    chk("b2b_din_ready", {63'b0, u_if.din_ready}, 64'd1);
    @(posedge clock); #1;
    u_if.din_valid  = 1'b0;
    u_if.dout_ready = 1'b0;
    chk("b2b_valid_drop", {63'b0, u_if.dout_valid}, 64'd0);
    wait_result(lat);
    chk("b2b_lat", 64'(lat), 64'd8);
    take_result(res);
    chk("b2b_rd", res, 64'h1);

    // Reset in the middle of an iteration discards the operation.
    accept_op(64'h15, 64'h3, 1'b0, FUNCT_CLDIV);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    chk("midrst_valid", {63'b0, u_if.dout_valid}, 64'd0);
    chk("midrst_din_ready", {63'b0, u_if.din_ready}, 64'd0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (u_if.dout_valid) seen = 1'b1;
    end
    chk("midrst_no_result", {63'b0, seen}, 64'd0);
    chk("midrst_din_ready_after", {63'b0, u_if.din_ready}, 64'd1);
    run_op(64'h31, 64'h7, 1'b0, FUNCT_CLDIV, res, lat);
    chk("midrst_next_q", res, 64'hB);

    for (int it = 0; it < 16; it++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ((it % 5) == 4) b = '0;
      w = 1'($urandom_range(0, 1));
      ref_divrem(a, b, w, eq, er);
      run_op(a, b, w, FUNCT_CLDIV, res_q, lat);
      chk("rnd_q", res_q, eq);
      chk("rnd_lat", 64'(lat), w ? 64'd4 : 64'd8);
      run_op(a, b, w, FUNCT_CLREM, res_r, lat);
      chk("rnd_r", res_r, er);
      if (b != '0) begin
        if (w) chk("rnd_recomb_w", clmul({32'b0, res_q[31:0]}, {32'b0, b[31:0]}) ^ {32'b0, res_r[31:0]},
                   {32'b0, a[31:0]});
        else   chk("rnd_recomb", clmul(res_q, b) ^ res_r, a);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
